// File: rtl/weights_ucode_sequencer.sv
// weights_ucode_sequencer: walks every Width/Depth address of one layer and
// emits the registered weight-fetch micro-code word {Width, Depth, Mode, Enable}.
// Weight_valid trails each issued address by one cycle, matching the RAM's
// registered output. A consumer Stall freezes the walk in place.
module weights_ucode_sequencer #(
    parameter int unsigned C1_DEPTH  = 8,
    parameter int unsigned C2_DEPTH  = 16,
    parameter int unsigned C2_WIDTH  = 8,
    parameter int unsigned C3_DEPTH  = 16,
    parameter int unsigned C3_WIDTH  = 8,
    parameter int unsigned FC1_DEPTH = 32,
    parameter int unsigned FC1_WIDTH = 16,
    parameter int unsigned FC2_WIDTH = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  layer_sel_i,
    input  logic        stall_i,
    output logic [14:0] ucode_o,
    output logic        weight_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t      state_q;
    logic [2:0]  layer_q;
    logic [3:0]  wid_q, wid_d;
    logic [4:0]  dep_q, dep_d;
    logic [4:0]  last_dep, last_wid5;
    logic [3:0]  last_wid;
    logic [14:0] ucode_q;
    logic        wv_q, busy_q, done_q, error_q;

    // One-hot mode field per layer; invalid selects give an all-zero mode.
    function automatic logic [4:0] mode_of(input logic [2:0] sel);
        case (sel)
            3'd0:    mode_of = 5'b10000;
            3'd1:    mode_of = 5'b01000;
            3'd2:    mode_of = 5'b00100;
            3'd3:    mode_of = 5'b00010;
            3'd4:    mode_of = 5'b00001;
            default: mode_of = 5'b00000;
        endcase
    endfunction

    // Terminal counter values for the latched layer (entry count minus one).
    always_comb begin
        last_dep  = 5'd0;
        last_wid5 = 5'd0;
        case (layer_q)
            3'd0: begin last_dep = 5'(C1_DEPTH - 1);  last_wid5 = 5'd0;                 end
            3'd1: begin last_dep = 5'(C2_DEPTH - 1);  last_wid5 = 5'(C2_WIDTH - 1);     end
            3'd2: begin last_dep = 5'(C3_DEPTH - 1);  last_wid5 = 5'(C3_WIDTH - 1);     end
            3'd3: begin last_dep = 5'(FC1_DEPTH - 1); last_wid5 = 5'(FC1_WIDTH - 1);    end
            3'd4: begin last_dep = 5'd0;              last_wid5 = 5'(FC2_WIDTH - 1);    end
            default: begin last_dep = 5'd0;           last_wid5 = 5'd0;                 end
        endcase
        last_wid = last_wid5[3:0];
    end

    // Next address: depth is the inner loop, width steps when depth wraps.
    always_comb begin
        wid_d = wid_q;
        dep_d = dep_q + 5'd1;
        if (dep_q == last_dep) begin
            dep_d = 5'd0;
            wid_d = wid_q + 4'd1;
        end
    end

    // Walk FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            layer_q <= 3'd0;
            wid_q   <= 4'd0;
            dep_q   <= 5'd0;
            ucode_q <= 15'd0;
            wv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            wv_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ucode_q <= 15'd0;
                    busy_q  <= 1'b0;
                    if (start_i) begin
                        if (layer_sel_i <= 3'd4) begin
                            layer_q <= layer_sel_i;
                            wid_q   <= 4'd0;
                            dep_q   <= 5'd0;
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            ucode_q <= {4'd0, 5'd0, mode_of(layer_sel_i), 1'b1};
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A stalled cycle holds counters and the word in place.
                    if (!stall_i) begin
                        wv_q <= 1'b1;
                        if (wid_q == last_wid && dep_q == last_dep) begin
                            state_q <= S_DRAIN;
                            ucode_q <= 15'd0;
                            done_q  <= 1'b1;
                        end else begin
                            wid_q   <= wid_d;
                            dep_q   <= dep_d;
                            ucode_q <= {wid_d, dep_d, mode_of(layer_q), 1'b1};
                        end
                    end
                end
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ucode_q <= 15'd0;
                end
            endcase
        end
    end

    assign ucode_o        = ucode_q;
    assign weight_valid_o = wv_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_weights_ucode_sequencer.sv
// Self-checking bench for weights_ucode_sequencer: each walk is compared per
// cycle against an entry list built from the layer dimensions.
module tb_weights_ucode_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stall;
    logic [2:0]  sel;
    logic [14:0] ucode;
    logic        wv, busy, done, error;

    int tests = 0;
    int fails = 0;
    logic [14:0] seen_q[$];

    weights_ucode_sequencer dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .layer_sel_i(sel),
        .stall_i(stall), .ucode_o(ucode), .weight_valid_o(wv), .busy_o(busy),
        .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;

    function automatic int dep_of(input int layer);
        case (layer)
            0: return 8;   1: return 16; 2: return 16; 3: return 32; default: return 1;
        endcase
    endfunction

    function automatic int wid_of(input int layer);
        case (layer)
            0: return 1;   1: return 8;  2: return 8;  3: return 16; default: return 5;
        endcase
    endfunction

    function automatic logic [14:0] word_of(input int layer, input int w, input int d);
        int v;
        v = w * 2048 + d * 64 + (1 << (4 - layer)) * 2 + 1;
        return v[14:0];
    endfunction

    // Called at a negedge; drives Start there and ends at the negedge where
    // the sequencer should be idle again. done_at counts cycles from Start.
    task automatic run_walk(input int layer, input int stall_pct, input int stall_at,
                            input int stall_len, input bit poke,
                            output int done_at, output int nstall, output int wvcnt);
        logic [14:0] exp_q[$];
        int idx = 0, c = 1, hold = 0, n;
        bit prev = 0, s;
        for (int w = 0; w < wid_of(layer); w++)
            for (int d = 0; d < dep_of(layer); d++)
                exp_q.push_back(word_of(layer, w, d));
        n = exp_q.size();
        seen_q.delete();
        nstall = 0; done_at = -1; wvcnt = 0;
        start = 1'b1; sel = 3'(layer);
        @(negedge clk);
        start = 1'b0;
        while (c < 3000) begin
            if (wv === 1'b1) wvcnt++;
            if (idx < n) begin
                tests++;
                if (ucode !== exp_q[idx] || busy !== 1'b1 || wv !== prev || done !== 1'b0) begin
                    fails++;
                    $display("FAIL run_cycle L%0d c%0d: ucode=%h busy=%b wv=%b done=%b, need ucode=%h busy=1 wv=%b done=0",
                             layer, c, ucode, busy, wv, done, exp_q[idx], prev);
                end
                if (idx == stall_at && hold < stall_len) begin s = 1'b1; hold++; end
                else s = ($urandom_range(99) < 32'(stall_pct));
                stall = s;
                if (poke) begin start = 1'($urandom); sel = 3'($urandom); end
                if (!s) begin seen_q.push_back(ucode); idx++; end
                else nstall++;
                prev = !s;
            end else begin
                tests++;
                if (ucode !== 15'd0 || wv !== 1'b1 || done !== 1'b1 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL drain L%0d: ucode=%h wv=%b done=%b busy=%b, need 0000 1 1 1",
                             layer, ucode, wv, done, busy);
                end
                done_at = c;
                stall = 1'($urandom);
                if (poke) begin start = 1'b1; sel = 3'd1; end
                @(negedge clk);
                start = 1'b0; stall = 1'b0;
                tests++;
                if (ucode !== 15'd0 || wv !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_after L%0d: ucode=%h wv=%b done=%b busy=%b, need all 0",
                             layer, ucode, wv, done, busy);
                end
                break;
            end
            @(negedge clk);
            c++;
        end
        tests++;
        if (done_at != n + nstall + 1) begin
            fails++;
            $display("FAIL done_time L%0d: got %0d, need %0d", layer, done_at, n + nstall + 1);
        end
        tests++;
        if (wvcnt != n || seen_q != exp_q) begin
            fails++;
            $display("FAIL entries L%0d: wv=%0d issued=%0d, need %0d in order", layer, wvcnt, seen_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0; sel = 3'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (ucode !== 15'd0 || wv !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reset: ucode=%h wv=%b busy=%b done=%b err=%b, need all 0", ucode, wv, busy, done, error);
        end
        reset = 1'b0;
    endtask

    task automatic test_layer0();
        int da, ns, wc;
        run_walk(0, 0, -1, 0, 1'b0, da, ns, wc);
        tests++;
        if (seen_q.size() != 8 || seen_q[0] !== 15'h0021 || seen_q[1] !== 15'h0061 ||
            seen_q[2] !== 15'h00A1 || seen_q[7] !== 15'h01E1 || da != 9 || wc != 8) begin
            fails++;
            $display("FAIL layer0: first=%h last=%h done_at=%0d wv=%0d, need 0021..01E1 9 8",
                     seen_q[0], seen_q[$], da, wc);
        end
    endtask

    task automatic test_layer1();
        int da, ns, wc;
        run_walk(1, 0, -1, 0, 1'b0, da, ns, wc);
        tests++;
        if (seen_q.size() != 128 || seen_q[0] !== 15'h0011 || seen_q[15] !== 15'h03D1 ||
            seen_q[16] !== 15'h0811 || seen_q[127] !== 15'h3BD1 || da != 129) begin
            fails++;
            $display("FAIL layer1: n=%0d last=%h done_at=%0d, need 128 3BD1 129", seen_q.size(), seen_q[$], da);
        end
    endtask

    task automatic test_layer4_error();
        int da, ns, wc;
        run_walk(4, 0, -1, 0, 1'b0, da, ns, wc);
        tests++;
        if (seen_q.size() != 5 || seen_q[0] !== 15'h0003 || seen_q[1] !== 15'h0803 ||
            seen_q[2] !== 15'h1003 || seen_q[3] !== 15'h1803 || seen_q[4] !== 15'h2003 || da != 6) begin
            fails++;
            $display("FAIL layer4: n=%0d last=%h done_at=%0d, need 5 2003 6", seen_q.size(), seen_q[$], da);
        end
        start = 1'b1; sel = 3'd6;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (error !== 1'b1 || busy !== 1'b0 || ucode !== 15'd0) begin
            fails++;
            $display("FAIL error_pulse: err=%b busy=%b ucode=%h, need 1 0 0000", error, busy, ucode);
        end
        @(negedge clk);
        tests++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL error_once: err=%b busy=%b, need 0 0", error, busy);
        end
    endtask

    // Stall held 3 cycles at (w2,d5) of FC_1st: one 3-cycle bubble.
    task automatic test_stall();
        int da, ns, wc;
        run_walk(3, 0, 2 * 32 + 5, 3, 1'b0, da, ns, wc);
        tests++;
        if (wc != 512 || ns != 3 || da != 516 || seen_q[69] !== word_of(3, 2, 5)) begin
            fails++;
            $display("FAIL stall: wv=%0d stalls=%0d done_at=%0d e69=%h, need 512 3 516 %h",
                     wc, ns, da, seen_q[69], word_of(3, 2, 5));
        end
    endtask

    task automatic test_reset_midwalk();
        int k;
        start = 1'b1; sel = 3'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        tests++;
        if (ucode !== word_of(2, 2, 8)) begin
            fails++;
            $display("FAIL entry40: ucode=%h, need %h", ucode, word_of(2, 2, 8));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (ucode !== 15'd0 || wv !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL midwalk_reset: ucode=%h wv=%b busy=%b done=%b, need all 0", ucode, wv, busy, done);
        end
        start = 1'b1; sel = 3'd2;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (ucode !== 15'h0009 || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart: ucode=%h busy=%b, need 0009 1", ucode, busy);
        end
        k = 0;
        while (busy === 1'b1 && k < 400) begin @(negedge clk); k++; end
        tests++;
        if (busy !== 1'b0 || k != 129) begin
            fails++;
            $display("FAIL restart_len: busy=%b cycles=%0d, need 0 129", busy, k);
        end
    endtask

    // Random layers and stalls, Start poked throughout RUN and on DRAIN,
    // each walk launched the cycle the previous one goes idle.
    task automatic test_back_to_back();
        int da, ns, wc;
        for (int i = 0; i < 8; i++)
            run_walk(int'($urandom_range(4)), 30, -1, 0, 1'b1, da, ns, wc);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; sel = 3'd0;
        test_reset();
        test_layer0();
        test_layer1();
        test_layer4_error();
        test_stall();
        test_reset_midwalk();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
